// File: rtl/ptmch_pkg.sv
// rtl/ptmch_pkg.sv - shared types and constants for the SPI-NAND pattern-match sequencer
package ptmch_pkg;

    localparam int TRG_W = 5;

    typedef enum logic [2:0] {
        PRGEXCT = 3'd0,
        RDSTAT  = 3'd1,
        BLKERS  = 3'd2,
        PDREAD  = 3'd3,
        WRSTAT  = 3'd4
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERS,
        S_ERS_POLL,
        S_PRG,
        S_PRG_POLL,
        S_RD,
        S_RD_POLL,
        S_GAP,
        S_NEXT,
        S_FIN,
        S_FAIL
    } seq_state_e;

    // Trigger bit index equals the command code; the top bit is never driven.
    function automatic logic [TRG_W-1:0] trg_onehot(input cmd_e c);
        logic [TRG_W-1:0] v;
        v = TRG_W'(1) << c;
        v[TRG_W-1] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/ptmch_seq_if.sv
// rtl/ptmch_seq_if.sv - command request/acknowledge link between sequencer and SPI engine
interface ptmch_seq_if;
    import ptmch_pkg::*;

    logic CMD_REQ;
    cmd_e CMD_CODE;
    logic CMD_ACK;
    logic STAT_OIP;

    modport master (output CMD_REQ, output CMD_CODE, input CMD_ACK, input STAT_OIP);
    modport slave  (input CMD_REQ, input CMD_CODE, output CMD_ACK, output STAT_OIP);

endinterface

// File: rtl/ptmch_pls_gen.sv
// rtl/ptmch_pls_gen.sv - one-hot trigger pulse of PLS_WIDTH cycles followed by an equal guard low time
module ptmch_pls_gen
    import ptmch_pkg::*;
#(
    parameter int PLS_WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fire_i,
    input  cmd_e             cmd_i,
    output logic [TRG_W-1:0] pls_o,
    output logic             rdy_o
);

    localparam logic [8:0] FULL = 9'(2 * PLS_WIDTH);
    localparam logic [8:0] OFF  = 9'(PLS_WIDTH + 1);

    logic [8:0]       cnt_q, cnt_d;
    logic [TRG_W-1:0] pls_q, pls_d;

    // cnt runs 2W..1: the upper W counts are the high phase, the lower W the guard.
    always_comb begin
        cnt_d = cnt_q;
        pls_d = pls_q;
        if (fire_i) begin
            cnt_d = FULL;
            pls_d = trg_onehot(cmd_i);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 9'd1;
            if (cnt_q == OFF) begin
                pls_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            pls_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pls_q <= pls_d;
        end
    end

    assign pls_o = pls_q;
    assign rdy_o = (cnt_q == '0);

endmodule

// File: rtl/ptmch_seq.sv
// rtl/ptmch_seq.sv - erase/program/read loop sequencer with read-status polling and trigger pulses
module ptmch_seq
    import ptmch_pkg::*;
#(
    parameter int PLS_WIDTH = 4,
    parameter int POLL_GAP  = 100,
    parameter int POLL_MAX  = 1000
) (
    input  logic             CLK100M,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [15:0]      LOOP_NUM,
    ptmch_seq_if.master      cmd,
    output logic [TRG_W-1:0] TRG_PLS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [15:0]      LOOP_CNT
);

    seq_state_e  state_q, state_d, ret_q, ret_d;
    logic        req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [16:0] loops_q, loops_d, tgt_q, tgt_d;
    logic [15:0] poll_q, poll_d, gap_q, gap_d;
    logic        fire, pls_rdy;
    cmd_e        code_c;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        loops_d = loops_q;
        tgt_d   = tgt_q;
        poll_d  = poll_q;
        gap_d   = gap_q;
        fire    = 1'b0;
        code_c  = PRGEXCT;

        case (state_q)
            S_ERS:                              code_c = BLKERS;
            S_RD:                               code_c = PDREAD;
            S_ERS_POLL, S_PRG_POLL, S_RD_POLL:  code_c = RDSTAT;
            default:                            code_c = PRGEXCT;
        endcase

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    loops_d = '0;
                    poll_d  = '0;
                    gap_d   = '0;
                    tgt_d   = (LOOP_NUM == 16'd0) ? 17'h10000 : {1'b0, LOOP_NUM};
                    state_d = S_ERS;
                end
            end
            S_ERS, S_PRG, S_RD, S_ERS_POLL, S_PRG_POLL, S_RD_POLL: begin
                // ABORT only takes effect once the previous pulse and its guard are over.
                if (!req_q) begin
                    if (pls_rdy) begin
                        if (ABORT) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            req_d = 1'b1;
                        end
                    end
                end else if (cmd.CMD_ACK) begin
                    req_d = 1'b0;
                    fire  = 1'b1;
                    case (state_q)
                        S_ERS: begin state_d = S_ERS_POLL; poll_d = '0; end
                        S_PRG: begin state_d = S_PRG_POLL; poll_d = '0; end
                        S_RD:  begin state_d = S_RD_POLL;  poll_d = '0; end
                        default: begin
                            poll_d = poll_q + 16'd1;
                            if (!cmd.STAT_OIP) begin
                                state_d = (state_q == S_ERS_POLL) ? S_PRG :
                                          (state_q == S_PRG_POLL) ? S_RD  : S_NEXT;
                            end else if (poll_q + 16'd1 == 16'(POLL_MAX)) begin
                                state_d = S_FAIL;
                            end else begin
                                ret_d   = state_q;
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end
                    endcase
                end
            end
            S_GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == 16'(POLL_GAP - 1)) begin
                    state_d = ret_q;
                end
            end
            S_NEXT: begin
                loops_d = loops_q + 17'd1;
                state_d = (loops_q + 17'd1 == tgt_q) ? S_FIN : S_ERS;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            loops_q <= '0;
            tgt_q   <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            loops_q <= loops_d;
            tgt_q   <= tgt_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
        end
    end

    ptmch_pls_gen #(.PLS_WIDTH(PLS_WIDTH)) u_pls (
        .clk_i  (CLK100M),
        .rst_ni (RESET_N),
        .fire_i (fire),
        .cmd_i  (code_c),
        .pls_o  (TRG_PLS),
        .rdy_o  (pls_rdy)
    );

    assign cmd.CMD_REQ  = req_q;
    assign cmd.CMD_CODE = code_c;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign LOOP_CNT     = loops_q[15:0];

endmodule
